// File: rtl/adder_share_arb.sv
// Round-robin share of one LAT-deep adder across NREQ requesters; results tagged with requester id, LAT edges after issue, no result backpressure.
// Define ADD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module adder_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 14,
  parameter int LAT   = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH:0]        add_sum,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH:0]        res_sum,
  output logic                  busy,
  output logic [15:0]           issue_cnt
);

  logic           grant_vld;
  logic [IDW-1:0] grant_id;

  logic [LAT-1:0] tag_vld_q;
  logic [IDW-1:0] tag_id_q [LAT];
  logic [15:0]    issue_cnt_q, issue_cnt_d;

`ifdef ADD_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    // Descending scan so the lowest valid index is the final assignment.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(i);
      end
    end
    if (!enable || !rst_n) begin
      grant_vld = 1'b0;
      grant_id  = '0;
    end
  end
`else
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    // Scan offsets from far to near so the nearest one after last wins.
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    if (!enable || !rst_n) begin
      grant_vld = 1'b0;
      grant_id  = '0;
    end
  end

  assign last_d = grant_vld ? grant_id : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (grant_vld) begin
      req_ready[grant_id] = 1'b1;
      add_a = req_a[grant_id*WIDTH +: WIDTH];
      add_b = req_b[grant_id*WIDTH +: WIDTH];
    end
  end

  assign issue_cnt_d = issue_cnt_q + {15'd0, grant_vld};

  // Tag pipe never stalls; it mirrors the adder's depth so ids line up with sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q   <= '0;
      issue_cnt_q <= '0;
      for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= grant_vld;
      tag_id_q[0]  <= grant_id;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign res_valid = tag_vld_q[LAT-1];
  assign res_id    = tag_id_q[LAT-1];
  assign res_sum   = res_valid ? add_sum : '0;
  assign busy      = |tag_vld_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Randomized bench for adder_share_arb with a two-stage adder stand-in and a queue-based reference model.
module tb_adder_share_arb;
  localparam int N   = 4;
  localparam int W   = 14;
  localparam int LAT = 2;
  localparam int IDW = $clog2(N);

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_a;
  logic [N*W-1:0]     req_b;
  logic [N-1:0]       req_ready;
  logic [W-1:0]       add_a;
  logic [W-1:0]       add_b;
  logic [W:0]         add_sum;
  logic               res_valid;
  logic [IDW-1:0]     res_id;
  logic [W:0]         res_sum;
  logic               busy;
  logic [15:0]        issue_cnt;

  adder_share_arb #(.NREQ(N), .WIDTH(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .busy(busy), .issue_cnt(issue_cnt)
  );

  // Two-stage adder sharing the arbiter's reset net.
  logic [W:0] s1, s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {1'b0, add_a} + {1'b0, add_b};
      s2 <= s1;
    end
  end
  assign add_sum = s2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; int id; logic [W:0] sum; } exp_t;
  exp_t        q[$];
  bit          pend [N];
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  int          m_last;
  logic [15:0] m_cnt;
  int          cyc;
  int          last_grant;
  int          n_chk;
  int          n_fail;
  int          grants[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic int winner();
    if (!enable) return -1;
`ifdef ADD_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (pend[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (pend[(m_last + k) % N]) return (m_last + k) % N;
`endif
    return -1;
  endfunction

  task automatic mreset();
    q.delete();
    m_last = N - 1;
    m_cnt  = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  // One cycle: drive requests, check every output against the model, advance to next edge.
  task automatic step(input bit gen, input int prob);
    int w;
    bit bexp;
    exp_t e;
    logic [31:0] rr;
    for (int i = 0; i < N; i++) begin
      if (gen && !pend[i] && int'($urandom_range(99)) < prob) begin
        pend[i] = 1'b1;
        op_a[i] = W'($urandom);
        op_b[i] = W'($urandom);
      end
      req_valid[i]     = pend[i];
      req_a[i*W +: W]  = op_a[i];
      req_b[i*W +: W]  = op_b[i];
    end
    #1;
    w  = winner();
    rr = (w >= 0) ? (32'd1 << w) : 32'd0;
    chk("req_ready", 32'(req_ready), rr);
    chk("add_a", 32'(add_a), (w >= 0) ? 32'(op_a[w]) : 32'd0);
    chk("add_b", 32'(add_b), (w >= 0) ? 32'(op_b[w]) : 32'd0);
    bexp = (q.size() != 0);
    chk("busy", 32'(busy), 32'(bexp));
    chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_id", 32'(res_id), 32'(e.id));
      chk("res_sum", 32'(res_sum), 32'(e.sum));
    end else begin
      chk("res_valid", 32'(res_valid), 32'd0);
      chk("res_id", 32'(res_id), 32'd0);
      chk("res_sum", 32'(res_sum), 32'd0);
    end
    if (w >= 0) begin
      e.due = cyc + LAT;
      e.id  = w;
      e.sum = {1'b0, op_a[w]} + {1'b0, op_b[w]};
      q.push_back(e);
      m_last = w;
      m_cnt  = m_cnt + 16'd1;
      pend[w] = 1'b0;
      grants.push_back(w);
    end
    last_grant = w;
    tick();
  endtask

  // Assert reset away from the edge, confirm outputs clear at once, hold two edges, release.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_add_a"}, 32'(add_a), 32'd0);
    chk({tag, "_resv"}, 32'(res_valid), 32'd0);
    chk({tag, "_sum"}, 32'(res_sum), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cnt"}, 32'(issue_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    mreset();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; last_grant = -1;
    rst_n = 1'b0; enable = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    mreset();
    #2;
    do_reset("rst0");

    // Single request from requester 0.
    pend[0] = 1'b1; op_a[0] = 14'h0005; op_b[0] = 14'h0003;
    step(0, 0);
    chk("single_grant", 32'(last_grant), 32'd0);
    step(0, 0);
    chk("single_resv", 32'(res_valid), 32'd1);
    chk("single_sum", 32'(res_sum), 32'h0008);
    chk("single_cnt", 32'(issue_cnt), 32'd1);
    step(0, 0);

    // Full-width overflow into bit 14.
    pend[2] = 1'b1; op_a[2] = 14'h3FFF; op_b[2] = 14'h3FFF;
    step(0, 0);
    step(0, 0);
    chk("ovf_sum", 32'(res_sum), 32'h7FFE);
    chk("ovf_id", 32'(res_id), 32'd2);
    step(0, 0);
    step(0, 0);

    // Fairness: all requesters held valid for 8 cycles from reset.
    do_reset("rst1");
    grants.delete();
    for (int i = 0; i < 8; i++) step(1, 100);
    for (int i = 0; i < 8; i++) begin
`ifdef ADD_ARB_FIXED_PRIO_EN
      chk("fair_order", 32'(grants[i]), 32'd0);
`else
      chk("fair_order", 32'(grants[i]), 32'(i % N));
`endif
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    step(0, 0);
    step(0, 0);

    // Enable drop with two ops in flight.
    step(1, 100);
    step(1, 100);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 100);
    chk("en_busy", 32'(busy), 32'd0);
    chk("en_cnt", 32'(issue_cnt), 32'd10);
    enable = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // Reset one cycle after an issue; that op must never report.
    pend[1] = 1'b1;
    step(0, 0);
    do_reset("rst_mid");
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; op_a[i] = W'(i + 1); op_b[i] = W'(i); end
    step(0, 0);
    chk("post_rst_first", 32'(last_grant), 32'd0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0);

    // Random traffic with random enable.
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(9) != 0);
      step(1, 40);
    end
    enable = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0);

    // Counter wrap after 65536 issues.
    do_reset("rst_wrap");
    for (int i = 0; i < 65536; i++) step(1, 100);
    chk("wrap_cnt", 32'(issue_cnt), 32'd0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter that shares one two-stage pipelined 15-bit-result adder among NREQ requesters. Each requester presents operand pairs over a valid/ready handshake. The block grants at most one requester per cycle and drives the winner's operands into the adder. It tags each issue with the requester index and returns the sum with that index exactly when the adder produces it. It sits between the requester blocks and the adder instance, and owns no arithmetic itself.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 14, operand width
- LAT, 2, adder latency in clock edges; must equal the adder's pipeline depth
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  1 = new grants permitted; 0 = no new issues, in-flight ops complete
- req_valid  input  NREQ  per-requester operand valid
- req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing
- req_ready  output  NREQ  one-hot grant; transfer on valid&ready at clk edge
- add_a  output  WIDTH  to adder input a
- add_b  output  WIDTH  to adder input b
- add_sum  input  WIDTH+1  from adder sum output
- res_valid  output  1  result valid, single-cycle pulse per op
- res_id  output  clog2(NREQ)  requester index of result
- res_sum  output  WIDTH+1  result value
- busy  output  1  any op in flight
- issue_cnt  output  16  total issued ops, wraps at 0xFFFF -> 0

## Operation
- Arbitration is combinational from req_valid, enable and the RR pointer `last` (registered index of the last grant).
- Search order: last+1, last+2, ... wrapping modulo NREQ. The first valid requester wins. req_ready is one-hot, or all-zero if enable=0 or no valid.
- req_ready may depend on req_valid. A requester must hold valid and operands stable until ready.
- add_a/add_b carry the winner's operands. They are 0 when there is no grant, so the adder computes 0 on idle cycles.
- On a grant edge:
  - `last` <= winner.
  - Tag stage 0 <= {1, winner}.
  - issue_cnt increments.
- Otherwise tag stage 0 <= {0, 0}.
- The tag shift register has LAT stages, no stall, and shifts every cycle.
- res_valid = tag[LAT-1].valid and res_id = tag[LAT-1].id.
- res_sum = add_sum when res_valid, else 0.
- Width: add_sum is the full WIDTH+1 unsigned sum and is not truncated. Example: 0x3FFF+0x3FFF = 0x7FFE.
- busy = OR of all tag valids.
- enable=0 blocks grants only. Tags keep shifting, so results still drain.
- Reset (asynchronous assert, synchronous release by upstream):
  - `last` = NREQ-1, so requester 0 wins first.
  - Tags, issue_cnt and all outputs = 0.
  - In-flight ops are discarded and never reported.
  - The adder's rst_n is tied to the same net. Its synchronous clear completes before the first post-reset grant, because tags are already 0.

## Timing
- Issue at edge T (valid&ready high before T) -> res_valid high in the cycle following edge T+LAT-1. With LAT=2: result appears one cycle after the cycle following the handshake.
- Throughput: one op per cycle. Back-to-back grants produce back-to-back res_valid pulses in issue order.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 grants.
- No result backpressure. Consumers must accept res_valid every cycle.
- Simultaneous enable fall and request: no grant that cycle.
- issue_cnt wraps silently.

## Configuration
- ADD_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. `last` is not used (tied off). Starvation of high indices is permitted.
  - Undefined: round-robin as above.
- Latency, tagging and all other behaviour are identical in both modes.

## Test plan
- Single request: req0 a=0x0005, b=0x0003 -> req_ready[0] in the same cycle; two edges later res_valid=1, res_id=0, res_sum=0x0008; issue_cnt=1.
- Overflow: a=0x3FFF, b=0x3FFF -> res_sum=0x7FFE (bit 14 set).
- All 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; res_id follows the same order, one per cycle, 2 cycles delayed. With ADD_ARB_FIXED_PRIO_EN: res_id is 0 every cycle.
- Enable: drop enable with 2 ops in flight -> no new req_ready; both results emerge; busy falls after the last one.
- Reset mid-flight: assert rst_n=0 one cycle after issue -> res_valid never pulses for that op; outputs 0 immediately; after release, requester 0 wins first.
- issue_cnt wrap: issue 65536 ops -> issue_cnt returns to 0.
